// File: rtl/rsa_decrypt_ctrl_if.sv
// ---------------------------------------------------------------------------
// rsa_decrypt_ctrl_if
//   Host-side bus of the RSA decryption controller.
//   Ports (signals):
//     in_valid  host -> ctrl  burst qualifier
//     in_p/in_q host -> ctrl  primes (WIDTH bits)
//     in_e      host -> ctrl  public exponent (2*WIDTH bits)
//     in_c      host -> ctrl  ciphertext (2*WIDTH bits)
//     out_valid ctrl -> host  plaintext qualifier
//     out_m     ctrl -> host  plaintext (2*WIDTH bits, 0 when not valid)
//   master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface rsa_decrypt_ctrl_if #(
    parameter int WIDTH = 4
) ();
    logic                 in_valid;
    logic [WIDTH-1:0]     in_p;
    logic [WIDTH-1:0]     in_q;
    logic [2*WIDTH-1:0]   in_e;
    logic [2*WIDTH-1:0]   in_c;
    logic                 out_valid;
    logic [2*WIDTH-1:0]   out_m;

    modport master (
        output in_valid, in_p, in_q, in_e, in_c,
        input  out_valid, out_m
    );

    modport slave (
        input  in_valid, in_p, in_q, in_e, in_c,
        output out_valid, out_m
    );
endinterface

// File: rtl/rsa_decrypt_ctrl.sv
// ---------------------------------------------------------------------------
// rsa_decrypt_ctrl
//   Captures a key triple (p, q, e) and a burst of NUM_C ciphertexts, derives
//   N and D through the combinational RSA_IP, then decrypts each ciphertext
//   with MSB-first square-and-multiply, one exponent bit per cycle over all
//   2*WIDTH bits of D (fixed latency). Plaintexts leave as one contiguous
//   burst of NUM_C cycles.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    rsa_decrypt_ctrl_if.slave (in_valid/in_p/in_q/in_e/in_c in,
//            out_valid/out_m out; outputs are registered)
//
// RSA_IP (same file)
//   Combinational key datapath: OUT_N = p*q, OUT_D = e^-1 mod (p-1)(q-1),
//   the smallest positive inverse, or 0 when no inverse exists.
// ---------------------------------------------------------------------------
module rsa_decrypt_ctrl #(
    parameter int WIDTH = 4,
    parameter int NUM_C = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    rsa_decrypt_ctrl_if.slave bus
);
    localparam int W2 = 2 * WIDTH;
    localparam int W4 = 4 * WIDTH;
    localparam int IW = (NUM_C > 1) ? $clog2(NUM_C) : 1;
    localparam int BW = $clog2(W2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KEY,
        S_EXP,
        S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  p_q, p_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [W2-1:0]     e_q, e_d;
    logic [W2-1:0]     n_q, n_d;
    logic [W2-1:0]     d_q, d_d;
    logic [W2-1:0]     r_q, r_d;
    logic [IW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     k_q, k_d;
    logic [IW-1:0]     oidx_q, oidx_d;
    logic [BW-1:0]     b_q, b_d;
    logic              out_valid_q, out_valid_d;
    logic [W2-1:0]     out_m_q, out_m_d;

    // Ciphertext and plaintext banks, one write enable per slot.
    logic [W2-1:0]     c_q [NUM_C];
    logic [W2-1:0]     m_q [NUM_C];
    logic [NUM_C-1:0]  c_we;
    logic [NUM_C-1:0]  m_we;

    logic [W2-1:0]     rsa_n, rsa_d;
    logic [W2-1:0]     c_cur;
    logic [W4-1:0]     n_ext, sq_full, mul_full;
    logic [W2-1:0]     sq_mod, mul_mod, r_step;
    logic [IW-1:0]     oidx_nx;

    RSA_IP #(
        .WIDTH (WIDTH)
    ) u_rsa_ip (
        .IN_P  (p_q),
        .IN_Q  (q_q),
        .IN_E  (e_q),
        .OUT_N (rsa_n),
        .OUT_D (rsa_d)
    );

    // -----------------------------------------------------------------------
    // One square-and-multiply step. Products are kept at 4*WIDTH bits so
    // nothing is lost before the reduction; c >= N is reduced by the mod.
    // N = 0 (out-of-contract key) yields 0 instead of a divide-by-zero.
    // -----------------------------------------------------------------------
    assign c_cur   = c_q[k_q];
    assign n_ext   = W4'(n_q);
    assign oidx_nx = oidx_q + IW'(1);

    always_comb begin
        sq_full  = W4'(r_q) * W4'(r_q);
        sq_mod   = (n_q == '0) ? '0 : W2'(sq_full % n_ext);
        mul_full = W4'(sq_mod) * W4'(c_cur);
        mul_mod  = (n_q == '0) ? '0 : W2'(mul_full % n_ext);
        r_step   = d_q[b_q] ? mul_mod : sq_mod;
    end

    // -----------------------------------------------------------------------
    // Next-state / datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        q_d         = q_q;
        e_d         = e_q;
        n_d         = n_q;
        d_d         = d_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        oidx_d      = oidx_q;
        b_d         = b_q;
        out_valid_d = out_valid_q;
        out_m_d     = out_m_q;
        c_we        = '0;
        m_we        = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    p_d     = bus.in_p;
                    q_d     = bus.in_q;
                    e_d     = bus.in_e;
                    c_we[0] = 1'b1;
                    cnt_d   = IW'(1);
                    state_d = (NUM_C == 1) ? S_KEY : S_LOAD;
                end
            end

            // A dropped in_valid simply holds here; cnt_q keeps the slot.
            S_LOAD: begin
                if (bus.in_valid) begin
                    c_we[cnt_q] = 1'b1;
                    if (cnt_q == IW'(NUM_C - 1)) begin
                        state_d = S_KEY;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end

            S_KEY: begin
                n_d     = rsa_n;
                d_d     = rsa_d;
                k_d     = '0;
                b_d     = BW'(W2 - 1);
                r_d     = W2'(1);
                state_d = S_EXP;
            end

            S_EXP: begin
                if (b_q == '0) begin
                    m_we[k_q] = 1'b1;
                    r_d       = W2'(1);
                    b_d       = BW'(W2 - 1);
                    if (k_q == IW'(NUM_C - 1)) begin
                        // First output goes out next cycle; with a single
                        // ciphertext it is the value being stored right now.
                        state_d     = S_OUT;
                        oidx_d      = '0;
                        out_valid_d = 1'b1;
                        out_m_d     = (k_q == '0) ? r_step : m_q[0];
                    end else begin
                        k_d = k_q + IW'(1);
                    end
                end else begin
                    r_d = r_step;
                    b_d = b_q - BW'(1);
                end
            end

            S_OUT: begin
                if (oidx_q == IW'(NUM_C - 1)) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    out_m_d     = '0;
                end else begin
                    oidx_d  = oidx_nx;
                    out_m_d = m_q[oidx_nx];
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            p_q         <= '0;
            q_q         <= '0;
            e_q         <= '0;
            n_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            k_q         <= '0;
            oidx_q      <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            out_m_q     <= '0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            q_q         <= q_d;
            e_q         <= e_d;
            n_q         <= n_d;
            d_q         <= d_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            oidx_q      <= oidx_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
            out_m_q     <= out_m_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_C; gi++) begin : g_bank
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    c_q[gi] <= '0;
                end else if (c_we[gi]) begin
                    c_q[gi] <= bus.in_c;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_q[gi] <= '0;
                end else if (m_we[gi]) begin
                    m_q[gi] <= r_step;
                end
            end
        end
    endgenerate

    assign bus.out_valid = out_valid_q;
    assign bus.out_m     = out_m_q;

endmodule

module RSA_IP #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]   IN_P,
    input  logic [WIDTH-1:0]   IN_Q,
    input  logic [2*WIDTH-1:0] IN_E,
    output logic [2*WIDTH-1:0] OUT_N,
    output logic [2*WIDTH-1:0] OUT_D
);
    localparam int W2 = 2 * WIDTH;
    localparam int W4 = 4 * WIDTH;

    logic [W2-1:0] phi;
    logic [W4-1:0] phi_ext;
    logic [W4-1:0] prod;
    logic [W2-1:0] cand;

    // Exhaustive inverse search. Scanning downwards lets the smallest valid
    // candidate win without a separate "found" flag.
    always_comb begin
        OUT_N   = W2'(IN_P) * W2'(IN_Q);
        phi     = W2'(IN_P - WIDTH'(1)) * W2'(IN_Q - WIDTH'(1));
        phi_ext = W4'(phi);
        OUT_D   = '0;
        prod    = '0;
        cand    = '0;
        for (int d = (1 << W2) - 1; d >= 1; d--) begin
            cand = W2'(d);
            prod = W4'(IN_E) * W4'(cand);
            if ((cand < phi) && ((prod % phi_ext) == W4'(1))) begin
                OUT_D = cand;
            end
        end
    end
endmodule

// File: tb/tb_rsa_decrypt_ctrl.sv
`timescale 1ns/1ps
module tb_rsa_decrypt_ctrl;
    localparam int NC = 4;

    typedef struct {
        int m;
        int t;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t q4[$];
    exp_t q3[$];
    exp_t e4, e3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rsa_decrypt_ctrl_if #(.WIDTH(4)) bus4 ();
    rsa_decrypt_ctrl_if #(.WIDTH(3)) bus3 ();

    rsa_decrypt_ctrl #(.WIDTH(4), .NUM_C(NC)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    rsa_decrypt_ctrl #(.WIDTH(3), .NUM_C(NC)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int gcd_ref(input int a, input int b);
        int x = a;
        int y = b;
        while (y != 0) begin
            int t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int modinv_ref(input int e, input int phi);
        int t = 0, nt = 1, r = phi, nr = e % phi, qq, tmp;
        while (nr != 0) begin
            qq  = r / nr;
            tmp = t - qq * nt; t = nt; nt = tmp;
            tmp = r - qq * nr; r = nr; nr = tmp;
        end
        if (r != 1) return 0;
        if (t < 0) t += phi;
        return t;
    endfunction

    function automatic int modpow_ref(input int c, input int d, input int n);
        int r = 1 % n;
        for (int i = 0; i < d; i++) r = (r * c) % n;
        return r;
    endfunction

    task automatic model_burst(input int p, input int q, input int e, input int c[NC], output int m[NC]);
        int n = p * q;
        int d = modinv_ref(e, (p - 1) * (q - 1));
        for (int i = 0; i < NC; i++) m[i] = modpow_ref(c[i], d, n);
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input int inst, input logic v, input int p, input int q, input int e, input int c);
        if (inst == 0) begin
            bus4.in_valid = v; bus4.in_p = 4'(p); bus4.in_q = 4'(q);
            bus4.in_e = 8'(e); bus4.in_c = 8'(c);
        end else begin
            bus3.in_valid = v; bus3.in_p = 3'(p); bus3.in_q = 3'(q);
            bus3.in_e = 6'(e); bus3.in_c = 6'(c);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    // Key is only valid on the first beat; later beats carry junk key fields.
    task automatic send(input int inst, input int p, input int q, input int e,
                        input int c[NC], input int gap, output int last);
        for (int i = 0; i < NC; i++) begin
            if (i == 2) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                    drive(inst, 1'b0, 0, 0, 0, int'($urandom_range(0, 255)));
                end
            end
            @(posedge clk); #1;
            if (i == 0) drive(inst, 1'b1, p, q, e, c[i]);
            else drive(inst, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 255)), c[i]);
            last = cyc;
        end
        @(posedge clk); #1;
        drive(inst, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic expect_burst(input int inst, input int last, input int m[NC]);
        exp_t x;
        int lat = (inst == 0) ? 2 + NC * 8 : 2 + NC * 6;
        for (int i = 0; i < NC; i++) begin
            x.m = m[i];
            x.t = last + lat + i;
            if (inst == 0) q4.push_back(x);
            else q3.push_back(x);
        end
        $display("burst inst=%0d last_in=%0d first_out_due=%0d m={%0d,%0d,%0d,%0d}",
                 inst, last, last + lat, m[0], m[1], m[2], m[3]);
    endtask

    task automatic pulse_at(input int inst, input int t);
        wait_cyc(t);
        drive(inst, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        @(posedge clk); #1;
        drive(inst, 1'b0, 0, 0, 0, 0);
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            check_val("rst_v4", bus4.out_valid, 0);
            check_val("rst_m4", bus4.out_m, 0);
        end else if (bus4.out_valid === 1'b1) begin
            if (q4.size() == 0) begin
                check_val("extra_v4", bus4.out_valid, 0);
            end else begin
                e4 = q4.pop_front();
                $display("out4 cyc=%0d m=%0d exp_m=%0d exp_cyc=%0d", cyc, bus4.out_m, e4.m, e4.t);
                check_val("m4", bus4.out_m, 64'(e4.m));
                check_val("t4", 64'(cyc), 64'(e4.t));
            end
        end else begin
            check_val("idle_m4", bus4.out_m, 0);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check_val("rst_v3", bus3.out_valid, 0);
            check_val("rst_m3", bus3.out_m, 0);
        end else if (bus3.out_valid === 1'b1) begin
            if (q3.size() == 0) begin
                check_val("extra_v3", bus3.out_valid, 0);
            end else begin
                e3 = q3.pop_front();
                $display("out3 cyc=%0d m=%0d exp_m=%0d exp_cyc=%0d", cyc, bus3.out_m, e3.m, e3.t);
                check_val("m3", bus3.out_m, 64'(e3.m));
                check_val("t3", 64'(cyc), 64'(e3.t));
            end
        end else begin
            check_val("idle_m3", bus3.out_m, 0);
        end
    end

    // ---------------- sequence ----------------
    initial begin
        int c[NC];
        int m[NC];
        int last;
        int p, q, e, phi, t0;
        int primes[5] = '{3, 5, 7, 11, 13};

        drive(0, 1'b0, 0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(cyc + 5);

        // Known-answer bursts, back to back.
        c = '{2, 8, 0, 1};        m = '{18, 2, 0, 1};
        send(0, 5, 11, 3, c, 0, last); expect_burst(0, last, m); wait_cyc(last + 37);

        c = '{54, 54, 8, 2};      m = '{54, 54, 2, 18};
        send(0, 5, 11, 3, c, 0, last); expect_burst(0, last, m); wait_cyc(last + 37);

        c = '{57, 255, 55, 110};  m = '{18, modpow_ref(200, 27, 55), 0, 0};
        send(0, 5, 11, 3, c, 0, last); expect_burst(0, last, m); wait_cyc(last + 37);

        // WIDTH = 3 instance.
        c = '{2, 20, 0, 4};       m = '{11, 20, 0, 16};
        send(1, 3, 7, 5, c, 0, last); expect_burst(1, last, m); wait_cyc(last + 29);

        // Abort mid-EXP: nothing may come out of this burst.
        c = '{3, 4, 5, 6};
        send(0, 5, 11, 3, c, 0, last);
        wait_cyc(last + 12);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_cyc(last + 60);

        c = '{7, 13, 42, 99};
        model_burst(5, 11, 3, c, m);
        send(0, 5, 11, 3, c, 0, last); expect_burst(0, last, m); wait_cyc(last + 37);

        // Random keys, LOAD gap, ignored pulses in KEY/EXP, back to back.
        for (int b = 0; b < 4; b++) begin
            p = primes[$urandom_range(0, 4)];
            do q = primes[$urandom_range(0, 4)]; while (q == p);
            phi = (p - 1) * (q - 1);
            e = int'($urandom_range(3, phi - 1));
            for (int k = 0; k < phi && gcd_ref(e, phi) != 1; k++) e = 3 + ((e - 2) % (phi - 3));
            if (gcd_ref(e, phi) != 1) e = phi - 1;
            for (int i = 0; i < NC; i++) c[i] = int'($urandom_range(0, 255));
            model_burst(p, q, e, c, m);
            send(0, p, q, e, c, 2, last);
            expect_burst(0, last, m);
            pulse_at(0, last + 1);
            pulse_at(0, last + 10);
            pulse_at(0, last + 20);
            wait_cyc(last + 37);
        end

        t0 = cyc;
        while ((q4.size() != 0 || q3.size() != 0) && cyc < t0 + 200) begin
            @(posedge clk); #1;
        end
        wait_cyc(cyc + 10);
        check_val("q4_left", 64'(q4.size()), 0);
        check_val("q3_left", 64'(q3.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rsa_decrypt_ctrl.md
Name: rsa_decrypt_ctrl

Overview:
- Sequential controller that wraps the combinational RSA key-generation datapath (RSA_IP: N = p*q, D = e^-1 mod (p-1)(q-1)).
- Flow: captures a key triple and a burst of ciphertexts, registers N and D once, then runs square-and-multiply modular exponentiation one exponent bit per cycle on each ciphertext.
- Recovered plaintexts stream out as a contiguous burst.
- Sits between the testbench/host handshake and the RSA_IP instance; RSA_IP is instantiated inside this block.

Parameters:
- WIDTH, 4, bit width of primes p and q; N, D, e, c, m are 2*WIDTH bits.
- NUM_C, 4, ciphertexts per burst (must be >= 1).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input burst qualifier
- in_p  input  WIDTH  prime p, sampled on first in_valid cycle only
- in_q  input  WIDTH  prime q, sampled on first in_valid cycle only
- in_e  input  2*WIDTH  public exponent e, sampled on first in_valid cycle only
- in_c  input  2*WIDTH  ciphertext, sampled every in_valid cycle
- out_valid  output  1  plaintext qualifier
- out_m  output  2*WIDTH  plaintext; 0 whenever out_valid = 0

Behaviour:
- Reset: rst_n low asynchronously clears everything.
  - State goes to IDLE; out_valid = 0, out_m = 0.
  - All key, ciphertext and accumulator registers clear to 0.
  - Reset mid-operation aborts the burst with no partial output.
- States: IDLE, LOAD, KEY, EXP, OUT.
- IDLE:
  - in_valid = 1: capture p, q, e, c[0]; load count = 1.
  - If NUM_C = 1, go to KEY; else go to LOAD.
- LOAD:
  - Each in_valid cycle stores c[count] and increments count.
  - After c[NUM_C-1] is stored, go to KEY.
  - in_valid low while in LOAD: hold state and resume on reassertion. The host is never expected to do this, but RTL must not lose data.
- KEY (1 cycle): register N = OUT_N and D = OUT_D from RSA_IP, driven by the captured p, q, e.
  - Initialise index k = 0, bit pointer b = 2*WIDTH-1, accumulator r = 1.
  - Go to EXP.
- EXP: one cycle per exponent bit, MSB first, over all 2*WIDTH bits of D (no leading-zero skip, so latency is fixed).
  - s = (r*r) mod N.
  - r <= D[b] ? (s*c[k]) mod N : s.
  - Intermediate products are 4*WIDTH bits wide; c >= N is legal and is reduced naturally by the mod.
  - When b = 0: store r as m[k], reset r = 1, set b = 2*WIDTH-1, increment k.
  - After k = NUM_C-1 completes, go to OUT.
- OUT: out_valid = 1 for exactly NUM_C consecutive cycles, out_m = m[0] .. m[NUM_C-1] in input order; then return to IDLE.
- Latency: if the last in_valid cycle is L, out_valid first rises at L + 2 + NUM_C*2*WIDTH (L+34 with defaults).
- in_valid asserted in KEY, EXP or OUT is ignored, and no register changes.
- in_valid is never asserted while out_valid = 1.
- A new burst may start in the cycle immediately after the last out_valid cycle.
- Degenerate keys (gcd(e,phi) != 1, or D = 0) are outside the contract. The block still produces NUM_C outputs with unchanged timing.
- Registered outputs only; no combinational path from inputs to outputs.

Test Plan:
- Reset values: hold rst_n low, then release → out_valid = 0 and out_m = 0 every cycle until a burst completes. Assert rst_n low for 1 cycle mid-EXP → out_valid never rises for that burst; the next full burst is correct.
- WIDTH=4, p=5, q=11, e=3 (N=55, D=27), c = {2, 8, 0, 1} → out_m = {18, 2, 0, 1}; out_valid 4 cycles, first at L+34.
- Same key, c = {54, 54, 8, 2} → out_m = {54, 54, 2, 18}. Checks c = N-1 and identical consecutive inputs.
- c >= N: same key, c = {57, 255, 55, 110} → out_m = {2^27 mod 55 = 18, 200^27 mod 55, 0, 0}. The bench computes the second value with a reference model.
- WIDTH=3, p=3, q=7, e=5 (N=21, D=5), c = {2, 20, 0, 4} → out_m = {11, 20, 0, 16}. Checks first out_valid at L+2+4*6 = L+26.
- Back-to-back bursts with random valid keys, in_valid gap of 2 cycles in LOAD, and in_valid pulses during EXP → every output matches the reference model; the ignored pulses cause no extra or shifted outputs.
